// File: rtl/tcdm_cfi_bank_responder.sv
// Flop-based single-ported TCDM bank that answers CFI requests from one crossbar
// slave port. Every granted access (read or write) produces exactly one response
// RESP_LAT cycles later. A clear sequence zero-fills the bank one word per cycle.
module tcdm_cfi_bank_responder #(
   parameter int unsigned CFI_DATA_WIDTH = 40,
   parameter int unsigned BE_WIDTH       = CFI_DATA_WIDTH / 8,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned NR_BANKS       = 4,
   parameter int unsigned BANK_SEL_LSB   = 2,
   parameter int unsigned DEPTH          = 256,
   parameter int unsigned RESP_LAT       = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_i,
   input  logic [ADDR_WIDTH-1:0]     add_i,
   input  logic                      wen_i,
   input  logic [BE_WIDTH-1:0]       be_i,
   input  logic [CFI_DATA_WIDTH-1:0] wdata_i,
   output logic                      gnt_o,
   output logic                      r_valid_o,
   output logic [CFI_DATA_WIDTH-1:0] r_rdata_o,
   output logic                      r_opc_o,
   input  logic                      clear_i,
   output logic                      busy_o,
   output logic                      clear_done_o
);

   // word index starts above the byte offset and the crossbar's bank-select field
   localparam int unsigned IDX_LSB = BANK_SEL_LSB + $clog2(NR_BANKS);
   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_DONE
   } state_e;

   state_e                             state_q, state_d;
   logic [AW-1:0]                      cnt_q, cnt_d;
   logic                               busy_q, busy_d;
   logic                               done_q, done_d;

   logic [ADDR_WIDTH-1:0]              idx;
   logic                               in_range;
   logic [AW-1:0]                      mem_idx;
   logic                               gnt;
   logic                               clr_we;
   logic [CFI_DATA_WIDTH-1:0]          rd_data;

   logic [CFI_DATA_WIDTH-1:0]          mem_q [DEPTH];

   logic [RESP_LAT-1:0]                pipe_valid_q, pipe_valid_d;
   logic [RESP_LAT-1:0]                pipe_opc_q, pipe_opc_d;
   logic [RESP_LAT-1:0][CFI_DATA_WIDTH-1:0] pipe_rdata_q, pipe_rdata_d;

   assign idx      = add_i >> IDX_LSB;
   assign in_range = (idx < ADDR_WIDTH'(DEPTH));
   assign mem_idx  = idx[AW-1:0];

   // a clear request wins over a same-cycle access; nothing is granted while in reset
   assign gnt    = rst_ni && req_i && !clear_i && (state_q == ST_IDLE);
   assign gnt_o  = gnt;
   assign clr_we = rst_ni && (state_q == ST_CLEAR);

   // read data is taken from the array at the grant edge; writes and out-of-range
   // accesses answer with zero data
   assign rd_data = (gnt && wen_i && in_range) ? mem_q[mem_idx] : '0;

   // clear sequencer next-state: walk cnt over every word, then pulse done once
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear_i) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         ST_CLEAR: begin
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // clear sequencer state and its registered status outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o       = busy_q;
   assign clear_done_o = done_q;

   // storage array: zero-fill during clear, otherwise byte-lane writes of granted in-range writes
   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         mem_q[cnt_q] <= '0;
      end else if (gnt && !wen_i && in_range) begin
         for (int b = 0; b < int'(BE_WIDTH); b++) begin
            if (be_i[b]) begin
               mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   // response shift register: stage 0 captures the grant, later stages just delay it
   always_comb begin
      pipe_valid_d    = pipe_valid_q;
      pipe_opc_d      = pipe_opc_q;
      pipe_rdata_d    = pipe_rdata_q;
      pipe_valid_d[0] = gnt;
      pipe_opc_d[0]   = gnt && !in_range;
      pipe_rdata_d[0] = rd_data;
      for (int s = 1; s < int'(RESP_LAT); s++) begin
         pipe_valid_d[s] = pipe_valid_q[s-1];
         pipe_opc_d[s]   = pipe_opc_q[s-1];
         pipe_rdata_d[s] = pipe_rdata_q[s-1];
      end
   end

   // response pipeline registers; reset drops anything in flight
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pipe_valid_q <= '0;
         pipe_opc_q   <= '0;
         pipe_rdata_q <= '0;
      end else begin
         pipe_valid_q <= pipe_valid_d;
         pipe_opc_q   <= pipe_opc_d;
         pipe_rdata_q <= pipe_rdata_d;
      end
   end

   // stage contents are zero unless valid, so the outputs read zero between responses
   assign r_valid_o = pipe_valid_q[RESP_LAT-1];
   assign r_opc_o   = pipe_opc_q[RESP_LAT-1];
   assign r_rdata_o = pipe_rdata_q[RESP_LAT-1];

endmodule
